median_filter_scalable: RTL and testbench
=========================================

MEDIAN_FILTER_SCALABLE -- requirements
Module: median_filter_scalable

Interface
REQ-001 The block SHALL have parameter SIZE, default 100, giving the number of input samples per vector (minimum 3).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the bit width of each sample.
REQ-003 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-006 The block SHALL have port in_valid, input, 1 bit: arr_in holds a new vector to filter this cycle.
REQ-007 The block SHALL have port arr_in, input, unpacked array [SIZE-1:0] of WIDTH bits: unsigned input samples, index 0 first.
REQ-008 The block SHALL have port arr_out, output, unpacked array [SIZE-3:0] of WIDTH bits: registered filtered samples.
REQ-009 The block SHALL have port out_valid, output, 1 bit: arr_out was updated by the previous accepted vector.

Function
REQ-010 The block SHALL compute a 1-D sliding-window median with window 3 and no edge padding: arr_out[i] = median(arr_in[i], arr_in[i+1], arr_in[i+2]) for i = 0..SIZE-3.
REQ-011 Samples SHALL be compared as unsigned WIDTH-bit values.
REQ-012 The median SHALL equal max(min(a,b), min(max(a,b),c)), and SHALL be exact when any or all of the three values are equal.
REQ-013 All SIZE-2 medians SHALL be computed in parallel by generated combinational comparator cells; there SHALL be no sequential scanning.
REQ-014 The block SHALL NOT widen or truncate samples; each arr_out element SHALL equal one of its three inputs bit-for-bit.
REQ-015 Latency SHALL be 1 cycle: when in_valid=1 at rising edge N, arr_out SHALL show the medians of that arr_in after edge N and out_valid SHALL be 1 after edge N.
REQ-016 When in_valid=0 at an edge, arr_out SHALL hold its previous value and out_valid SHALL be 0 after that edge.
REQ-017 Back-to-back vectors SHALL be accepted on every cycle with in_valid=1, with no stalls or bubbles (throughput 1 vector/cycle).
REQ-018 There SHALL be no backpressure; the block is always ready.
REQ-019 Changes on arr_in between clock edges SHALL NOT affect arr_out; the output is fully registered.
REQ-020 Elaboration SHALL fail for SIZE < 3, using a generate-time error or assertion.

Reset
REQ-021 When rst_n=0 at a rising edge, every arr_out element SHALL become 0 and out_valid SHALL become 0, regardless of in_valid.
REQ-022 Reset SHALL take priority over in_valid=1 on the same edge; the vector presented on that edge SHALL be discarded.
REQ-023 An asserted rst_n mid-stream SHALL clear the outputs at the next edge; the first vector after release SHALL appear 1 cycle after it is accepted.
REQ-024 The block SHALL have no state other than the arr_out and out_valid registers.

Verification
REQ-025 Basic filtering, SIZE=5: arr_in={idx0..4: 10,50,20,20,90}, in_valid=1 -> next cycle arr_out={20,20,20}, out_valid=1.
REQ-026 Impulse rejection, SIZE=100: all samples 0x40 except arr_in[50]=0xFF, then arr_in[51]=0x00 -> every arr_out element = 0x40.
REQ-027 Unsigned extremes and ties: window (0xFF,0x00,0x80) -> 0x80; window (0x00,0x00,0xFF) -> 0x00; window (7,7,7) -> 7.
REQ-028 Streaming: three consecutive distinct vectors with in_valid=1 -> three consecutive cycles of correct outputs with out_valid=1; then in_valid=0 -> arr_out holds and out_valid=0.
REQ-029 Reset: outputs non-zero, then rst_n=0 with in_valid=1 -> after the edge all arr_out=0 and out_valid=0; release rst_n and apply a vector -> correct output 1 cycle later.
REQ-030 Randomized self-check: 1000 random vectors (SIZE=100, WIDTH=8) compared against a sort-based reference median -> zero mismatches.

Source files
------------

// File: rtl/median_filter_scalable.sv
// Sliding window-3 median over a SIZE-sample vector, all windows in parallel,
// with one registered output stage.
module median_filter_scalable #(
  parameter int SIZE  = 100,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] arr_in  [SIZE-1:0],
  output logic [WIDTH-1:0] arr_out [SIZE-3:0],
  output logic             out_valid
);

  if (SIZE < 3) begin : g_size_check
    $error("median_filter_scalable: SIZE must be at least 3");
  end

  logic [WIDTH-1:0] med [SIZE-3:0];

  // median = max(min(a,b), min(max(a,b),c)); exact on ties, always one of a/b/c
  for (genvar g = 0; g < SIZE - 2; g++) begin : g_cell
    logic [WIDTH-1:0] a, b, c, lo, hi, hc;
    assign a      = arr_in[g];
    assign b      = arr_in[g+1];
    assign c      = arr_in[g+2];
    assign lo     = (a < b) ? a : b;
    assign hi     = (a < b) ? b : a;
    assign hc     = (hi < c) ? hi : c;
    assign med[g] = (lo > hc) ? lo : hc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < SIZE - 2; i++) arr_out[i] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) arr_out <= med;
    end
  end

endmodule

// File: tb/tb_median_filter_scalable.sv
// Self-checking bench for median_filter_scalable: directed cases plus randomized
// vectors against a sort-based window median model.
module tb_median_filter_scalable;
  localparam int SIZE  = 100;
  localparam int WIDTH = 8;
  localparam int NOUT  = SIZE - 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] arr_in  [SIZE-1:0];
  logic [WIDTH-1:0] arr_out [NOUT-1:0];
  logic             out_valid;

  logic             in_valid5;
  logic [WIDTH-1:0] arr_in5  [4:0];
  logic [WIDTH-1:0] arr_out5 [2:0];
  logic             out_valid5;

  logic [WIDTH-1:0] exp_out [NOUT-1:0];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  median_filter_scalable #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .arr_in(arr_in), .arr_out(arr_out), .out_valid(out_valid)
  );

  median_filter_scalable #(.SIZE(5), .WIDTH(WIDTH)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5),
    .arr_in(arr_in5), .arr_out(arr_out5), .out_valid(out_valid5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Middle element of the three values after sorting them.
  function automatic int ref_median(input int x, input int y, input int z);
    int v [3];
    int t;
    v[0] = x; v[1] = y; v[2] = z;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[1];
  endfunction

  task automatic model_accept();
    for (int i = 0; i < NOUT; i++)
      exp_out[i] = WIDTH'(ref_median(int'(arr_in[i]), int'(arr_in[i+1]), int'(arr_in[i+2])));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic want_valid);
    check({tag, ".valid"}, 32'(out_valid), 32'(want_valid));
    for (int i = 0; i < NOUT; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(arr_out[i]), 32'(exp_out[i]));
  endtask

  task automatic rand_vec(input int mode);
    for (int i = 0; i < SIZE; i++)
      arr_in[i] = (mode == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3) * 85);
  endtask

  initial begin
    int accepted;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_valid5 = 1'b1;
    rand_vec(0);
    for (int i = 0; i < 5; i++) arr_in5[i] = 8'hAA;

    // reset wins over in_valid
    step();
    for (int i = 0; i < NOUT; i++) exp_out[i] = '0;
    check_vec("reset", 1'b0);
    check("reset5.valid", 32'(out_valid5), 32'd0);

    // basic SIZE=5 filtering
    rst_n = 1'b1;
    arr_in5[0] = 8'd10; arr_in5[1] = 8'd50; arr_in5[2] = 8'd20;
    arr_in5[3] = 8'd20; arr_in5[4] = 8'd90;
    in_valid = 1'b0;
    step();
    check("basic5.valid", 32'(out_valid5), 32'd1);
    for (int i = 0; i < 3; i++)
      check($sformatf("basic5[%0d]", i), 32'(arr_out5[i]), 32'd20);
    check("idle.valid", 32'(out_valid), 32'd0);
    in_valid5 = 1'b0;

    // impulse rejection
    for (int i = 0; i < SIZE; i++) arr_in[i] = 8'h40;
    arr_in[50] = 8'hFF;
    arr_in[51] = 8'h00;
    in_valid = 1'b1;
    step();
    check("impulse.valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < NOUT; i++)
      check($sformatf("impulse[%0d]", i), 32'(arr_out[i]), 32'h40);

    // unsigned extremes and ties
    rand_vec(0);
    arr_in[0]  = 8'hFF; arr_in[1]  = 8'h00; arr_in[2]  = 8'h80;
    arr_in[10] = 8'h00; arr_in[11] = 8'h00; arr_in[12] = 8'hFF;
    arr_in[20] = 8'd7;  arr_in[21] = 8'd7;  arr_in[22] = 8'd7;
    model_accept();
    step();
    check("ext.ff_00_80", 32'(arr_out[0]), 32'h80);
    check("ext.00_00_ff", 32'(arr_out[10]), 32'h00);
    check("ext.7_7_7", 32'(arr_out[20]), 32'd7);
    check_vec("ext", 1'b1);

    // streaming, then hold
    for (int k = 0; k < 3; k++) begin
      rand_vec(k % 2);
      model_accept();
      step();
      check_vec($sformatf("stream%0d", k), 1'b1);
    end
    rand_vec(0);
    in_valid = 1'b0;
    step();
    check_vec("hold", 1'b0);

    // inputs moving between edges do not reach the output
    in_valid = 1'b1;
    rand_vec(0);
    model_accept();
    step();
    rand_vec(0);
    #3;
    check_vec("regout", 1'b1);

    // mid-stream reset with in_valid=1, then recovery
    rst_n = 1'b0;
    step();
    for (int i = 0; i < NOUT; i++) exp_out[i] = '0;
    check_vec("midreset", 1'b0);
    rst_n = 1'b1;
    rand_vec(0);
    model_accept();
    step();
    check_vec("postreset", 1'b1);

    // randomized: 1000 accepted vectors with occasional idle cycles
    accepted = 0;
    while (accepted < 1000) begin
      logic v;
      v = ($urandom_range(0, 7) != 0);
      in_valid = v;
      rand_vec($urandom_range(0, 1));
      if (v) begin
        model_accept();
        accepted++;
      end
      step();
      check_vec("rand", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
